// File: rtl/video_pointer_pkg.sv
// Shared constants, register map and FSM state encoding for the video pointer loader.
// The CLEAR state exists only when VIDEO_POINTER_LOADER_CLEAR_EN is defined.
package video_pointer_pkg;

    localparam int unsigned RAM_DEPTH = 2048;
    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned DATA_W    = 16;

    localparam logic [ADDR_W-1:0] RAM_LAST = ADDR_W'(RAM_DEPTH - 1);

    localparam logic [1:0] REG_ADDR = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACK,
        ST_RELEASE
`ifdef VIDEO_POINTER_LOADER_CLEAR_EN
        , ST_CLEAR
`endif
    } state_t;

endpackage

// File: rtl/video_pointer_loader_if.sv
// Host register bus: request/ack handshake with a 2-bit register select.
interface video_pointer_loader_if;

    logic        bus_sel;
    logic        bus_we;
    logic [1:0]  bus_reg;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_sel, bus_we, bus_reg, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_sel, bus_we, bus_reg, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/video_pointer_loader.sv
// Host-driven loader for the pointer RAM: auto-incrementing ADDR/DATA port, fixed 2-cycle ack.
// Define VIDEO_POINTER_LOADER_CLEAR_EN to build in the RAM clear engine (CTRL bit0).
module video_pointer_loader
    import video_pointer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    video_pointer_loader_if.slave bus,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [DATA_W-1:0] ram_w_data,
    output logic              ram_w_enable,
    output logic              ram_w_clk_enable,
    output logic              busy
);

    state_t            state;
    logic [1:0]        lat_reg;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_wdata;
    logic [ADDR_W-1:0] addr;

`ifdef VIDEO_POINTER_LOADER_CLEAR_EN
    logic              clear_req;
`else
    assign busy = 1'b0;
`endif

    // Both RAM strobes come from the same flop.
    assign ram_w_clk_enable = ram_w_enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            lat_reg       <= REG_ADDR;
            lat_we        <= 1'b0;
            lat_wdata     <= '0;
            addr          <= '0;
            bus.bus_ack   <= 1'b0;
            bus.bus_rdata <= '0;
            ram_w_addr    <= '0;
            ram_w_data    <= '0;
            ram_w_enable  <= 1'b0;
`ifdef VIDEO_POINTER_LOADER_CLEAR_EN
            clear_req     <= 1'b0;
            busy          <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.bus_sel) begin
                        lat_reg      <= bus.bus_reg;
                        lat_we       <= bus.bus_we;
                        lat_wdata    <= bus.bus_wdata[ADDR_W-1:0];
                        ram_w_addr   <= addr;
                        ram_w_data   <= bus.bus_wdata;
                        // Strobe is registered so it is high exactly during ACCESS.
                        ram_w_enable <= bus.bus_we && (bus.bus_reg == REG_DATA);
                        state        <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    ram_w_enable  <= 1'b0;
                    bus.bus_ack   <= 1'b1;
                    bus.bus_rdata <= '0;
                    case (lat_reg)
                        REG_ADDR: begin
                            if (lat_we) addr <= lat_wdata;
                            else        bus.bus_rdata <= DATA_W'(addr);
                        end
                        REG_DATA: begin
                            if (lat_we) addr <= addr + ADDR_W'(1);
                        end
                        REG_CTRL: begin
                            if (!lat_we) bus.bus_rdata <= DATA_W'(busy);
`ifdef VIDEO_POINTER_LOADER_CLEAR_EN
                            else if (lat_wdata[0]) clear_req <= 1'b1;
`endif
                        end
                        default: ;
                    endcase
                    state <= ST_ACK;
                end

                ST_ACK: begin
                    bus.bus_ack   <= 1'b0;
                    bus.bus_rdata <= '0;
`ifdef VIDEO_POINTER_LOADER_CLEAR_EN
                    if (clear_req) begin
                        clear_req    <= 1'b0;
                        busy         <= 1'b1;
                        ram_w_enable <= 1'b1;
                        ram_w_addr   <= '0;
                        ram_w_data   <= '0;
                        state        <= ST_CLEAR;
                    end else begin
                        state <= ST_RELEASE;
                    end
`else
                    state <= ST_RELEASE;
`endif
                end

                ST_RELEASE: begin
                    if (!bus.bus_sel) state <= ST_IDLE;
                end

`ifdef VIDEO_POINTER_LOADER_CLEAR_EN
                // One zero word per cycle; a request waiting on bus_sel is picked up from IDLE.
                ST_CLEAR: begin
                    if (ram_w_addr == RAM_LAST) begin
                        ram_w_enable <= 1'b0;
                        busy         <= 1'b0;
                        addr         <= '0;
                        state        <= ST_IDLE;
                    end else begin
                        ram_w_addr <= ram_w_addr + ADDR_W'(1);
                    end
                end
`endif

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
